// File: rtl/lot_occupancy_tracker_pkg.sv
// Shared constants for the lot occupancy tracker: default sizing, converter
// state encodings and the double-dabble digit correction.
package lot_occupancy_tracker_pkg;

  localparam int CAPACITY_DEFAULT = 99;
  localparam int W_DEFAULT        = 7;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OP   = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Digits of 5 or more are pre-corrected so the following shift carries into the next digit.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/lot_occupancy_tracker_bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle into two BCD digits.
// start is accepted only while ready; done is a one-cycle pulse carrying a valid bcd1/bcd0.
module bin2bcd_seq
  import lot_occupancy_tracker_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic [1:0]   state_dbg
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [7:0]     acc;
  logic [W-1:0]   sh;
  logic [7:0]     acc_adj;
  logic [8+W-1:0] shifted;

  always_comb begin
    acc_adj = {dabble_adj(acc[7:4]), dabble_adj(acc[3:0])};
    shifted = {acc_adj, sh} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh    <= bin;
            acc   <= '0;
            cnt   <= '0;
            state <= S_OP;
          end
        end
        S_OP: begin
          acc <= shifted[8+W-1:W];
          sh  <= shifted[W-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign bcd1      = acc[7:4];
  assign bcd0      = acc[3:0];
  assign state_dbg = state;

endmodule

// File: rtl/lot_occupancy_tracker.sv
// Parking-lot occupancy counter with full/empty flags, sticky over/underflow
// errors and a BCD copy of the count that only ever shows completed conversions.
module lot_occupancy_tracker
  import lot_occupancy_tracker_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEFAULT,
  parameter int W        = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enter,
  input  logic         exit,
  input  logic         clr_err,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         err_over,
  output logic         err_under,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic         bcd_valid,
  output logic [1:0]   conv_state
);

  localparam logic [W-1:0] CAP = W'(CAPACITY);
  localparam logic [W-1:0] ONE = W'(1);

  logic         inc;
  logic         dec;
  logic         count_chg;
  logic         over_hit;
  logic         under_hit;
  logic         conv_start;
  logic         conv_ready;
  logic         conv_done;
  logic [3:0]   conv_bcd1;
  logic [3:0]   conv_bcd0;
  logic [W-1:0] sent;
  logic         pending;
  logic         load;

  assign full  = (count == CAP);
  assign empty = (count == '0);

  // Simultaneous enter and exit cancel out and are never an error.
  assign inc       = enter & ~exit & ~full;
  assign dec       = exit & ~enter & ~empty;
  assign over_hit  = enter & ~exit & full;
  assign under_hit = exit & ~enter & empty;
  assign count_chg = inc | dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end else if (dec) begin
      count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else begin
      if (over_hit)      err_over <= 1'b1;
      else if (clr_err)  err_over <= 1'b0;
      if (under_hit)     err_under <= 1'b1;
      else if (clr_err)  err_under <= 1'b0;
    end
  end

  // A conversion is requested whenever the register disagrees with what was last
  // sent, or a change arrived while the previous conversion was still in flight.
  assign conv_start = conv_ready & ((count != sent) | pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      sent    <= '0;
      pending <= 1'b0;
    end else begin
      if (conv_start) sent <= count;
      if (count_chg && (!conv_ready || conv_start)) pending <= 1'b1;
      else if (conv_start)                          pending <= 1'b0;
    end
  end

  // A result is only good if no count change happened since its conversion began.
  assign load = conv_done & ~pending & ~count_chg;

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd1      <= 4'd0;
      bcd0      <= 4'd0;
      bcd_valid <= 1'b1;
    end else begin
      if (load) begin
        bcd1 <= conv_bcd1;
        bcd0 <= conv_bcd0;
      end
      if (count_chg) bcd_valid <= 1'b0;
      else if (load) bcd_valid <= 1'b1;
    end
  end

  bin2bcd_seq #(.W(W)) u_conv (
    .clk       (clk),
    .reset     (reset),
    .start     (conv_start),
    .bin       (count),
    .ready     (conv_ready),
    .done      (conv_done),
    .bcd1      (conv_bcd1),
    .bcd0      (conv_bcd0),
    .state_dbg (conv_state)
  );

endmodule
